// File: rtl/pwm_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pwm_cfg_pkg
// Shared encodings for the PWM timer configuration scheduler:
//   count_mode_e : timer counting mode (stop / down / up / up-down)
//   upd_mode_e   : when a pending configuration is committed
//   sync_mode_e  : which channel-0 carrier event drives the sync pulse
//   ch_state_e   : per-channel scheduler state
// event_select() picks the event for an update/sync selector. Both selectors
// use the same codes for zero/max/both; only code 00 differs (immediate vs. off),
// so the caller passes the value that code 00 should produce.
// -----------------------------------------------------------------------------
package pwm_cfg_pkg;

  typedef enum logic [1:0] {
    CM_STOP   = 2'b00,
    CM_DOWN   = 2'b01,
    CM_UP     = 2'b10,
    CM_UPDOWN = 2'b11
  } count_mode_e;

  typedef enum logic [1:0] {
    UPD_IMM  = 2'b00,
    UPD_ZERO = 2'b01,
    UPD_MAX  = 2'b10,
    UPD_BOTH = 2'b11
  } upd_mode_e;

  typedef enum logic [1:0] {
    SYNC_OFF  = 2'b00,
    SYNC_ZERO = 2'b01,
    SYNC_MAX  = 2'b10,
    SYNC_BOTH = 2'b11
  } sync_mode_e;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } ch_state_e;

  function automatic logic event_select(input logic [1:0] sel,
                                        input logic       hit_zero,
                                        input logic       hit_max,
                                        input logic       sel_none);
    case (upd_mode_e'(sel))
      UPD_IMM:  return sel_none;
      UPD_ZERO: return hit_zero;
      UPD_MAX:  return hit_max;
      default:  return hit_zero | hit_max;
    endcase
  endfunction

endpackage

// File: rtl/pwm_timer_cfg_sched_if.sv
// -----------------------------------------------------------------------------
// pwm_timer_cfg_sched_if
// Valid/ready configuration write port of the scheduler.
//   wr_valid / wr_ready : handshake, transfer when both are high at posedge clk
//   wr_ch               : target channel
//   wr_count_max        : new timer period
//   wr_init_carr        : new initial carrier
//   wr_count_mode       : new counting mode (count_mode_e encoding)
//   wr_upd_mode         : commit condition (upd_mode_e encoding)
// master drives the request, slave (the scheduler) returns wr_ready.
// -----------------------------------------------------------------------------
interface pwm_timer_cfg_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 16
);
  localparam int CHW = $clog2(NCH);

  logic           wr_valid;
  logic           wr_ready;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_count_max;
  logic [CW-1:0]  wr_init_carr;
  logic [1:0]     wr_count_mode;
  logic [1:0]     wr_upd_mode;

  modport master (
    output wr_valid, wr_ch, wr_count_max, wr_init_carr, wr_count_mode, wr_upd_mode,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_ch, wr_count_max, wr_init_carr, wr_count_mode, wr_upd_mode,
    output wr_ready
  );
endinterface

// File: rtl/pwm_cfg_channel.sv
// -----------------------------------------------------------------------------
// pwm_cfg_channel
// One channel of the configuration scheduler: shadow registers, active
// registers driving the timer, IDLE/ARMED state machine and the carrier event
// compare.
//   clk, rst        : clock, synchronous active-high reset
//   ce              : clock enable for event evaluation / commit
//   load            : accepted write addressed to this channel
//   ld_*            : write payload captured into the shadow on load
//   carrier         : live carrier of this channel's timer
//   count_max,
//   init_carr,
//   count_mode      : active configuration driven to the timer
//   pending         : shadow holds a configuration not yet committed
//   commit          : one-cycle pulse in the cycle following a commit edge
// -----------------------------------------------------------------------------
module pwm_cfg_channel
  import pwm_cfg_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          load,
  input  logic [CW-1:0] ld_count_max,
  input  logic [CW-1:0] ld_init_carr,
  input  logic [1:0]    ld_count_mode,
  input  logic [1:0]    ld_upd_mode,
  input  logic [CW-1:0] carrier,
  output logic [CW-1:0] count_max,
  output logic [CW-1:0] init_carr,
  output logic [1:0]    count_mode,
  output logic          pending,
  output logic          commit
);

  ch_state_e     state;
  logic [CW-1:0] sh_count_max;
  logic [CW-1:0] sh_init_carr;
  logic [1:0]    sh_count_mode;
  logic [1:0]    sh_upd_mode;

  logic [CW-1:0] count_max_m1;
  logic          hit_zero;
  logic          hit_max;
  logic          stopped;
  logic          fire;

  // All compares use the active (pre-commit) configuration. An up-counting
  // timer wraps at count_max-1, so that value also counts as the max event.
  // count_max-1 wraps when count_max is 0, but that case is caught by stopped.
  assign count_max_m1 = count_max - CW'(1);
  assign hit_zero     = (carrier == '0);
  assign hit_max      = (carrier == count_max) ||
                        ((count_mode == CM_UP) && (carrier == count_max_m1));
  // A stopped timer has no period to protect, so it takes new settings at once.
  assign stopped      = (count_mode == CM_STOP) || (count_max == '0);
  assign fire         = stopped || event_select(sh_upd_mode, hit_zero, hit_max, 1'b1);

  // NOTE: every register here is state, so it is updated with non-blocking
  // assignments; blocking ones would let the commit see same-edge shadow data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CH_IDLE;
      sh_count_max  <= '0;
      sh_init_carr  <= '0;
      sh_count_mode <= '0;
      sh_upd_mode   <= '0;
      count_max     <= '0;
      init_carr     <= '0;
      count_mode    <= '0;
      pending       <= 1'b0;
      commit        <= 1'b0;
    end else begin
      commit <= 1'b0;
      unique case (state)
        CH_IDLE: begin
          if (load) begin
            sh_count_max  <= ld_count_max;
            sh_init_carr  <= ld_init_carr;
            sh_count_mode <= ld_count_mode;
            sh_upd_mode   <= ld_upd_mode;
            pending       <= 1'b1;
            state         <= CH_ARMED;
          end
        end
        CH_ARMED: begin
          if (ce && fire) begin
            count_max  <= sh_count_max;
            init_carr  <= sh_init_carr;
            count_mode <= sh_count_mode;
            pending    <= 1'b0;
            commit     <= 1'b1;
            state      <= CH_IDLE;
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pwm_timer_cfg_sched.sv
// -----------------------------------------------------------------------------
// pwm_timer_cfg_sched
// Configuration scheduler for a bank of NCH PWM timers. Settings arrive on a
// valid/ready write port, are held per channel and committed to the timer only
// at a safe carrier event, so a running PWM period is never cut short.
//   clk, rst        : clock, synchronous active-high reset
//   ce              : clock enable for event evaluation and commits
//   wr              : write port (slave side of pwm_timer_cfg_sched_if)
//   carrier_in      : live carriers, channel k at [k*CW +: CW]
//   tmr_count_max   : active periods to the timers
//   tmr_init_carr   : active initial carriers to the timers
//   tmr_count_mode  : active modes to the timers, channel k at [k*2 +: 2]
//   pending         : per-channel "configuration waiting for its event"
//   commit          : per-channel pulse the cycle after the active values change
//   sync_mode       : channel-0 event selecting the sync pulse (00 = off)
//   sync_out        : registered period-sync pulse
// -----------------------------------------------------------------------------
module pwm_timer_cfg_sched
  import pwm_cfg_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  pwm_timer_cfg_sched_if.slave wr,
  input  logic [NCH*CW-1:0] carrier_in,
  output logic [NCH*CW-1:0] tmr_count_max,
  output logic [NCH*CW-1:0] tmr_init_carr,
  output logic [NCH*2-1:0]  tmr_count_mode,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    commit,
  input  logic [1:0]        sync_mode,
  output logic              sync_out
);

  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0] load;
  logic           wr_ready_c;

  // Write decode: the port is ready unless the addressed channel is still
  // holding an uncommitted configuration. Out-of-range channel numbers (when
  // NCH is not a power of two) are accepted and dropped.
  // NOTE: both outputs get a default before the loop so no latch is inferred.
  always_comb begin
    wr_ready_c = 1'b1;
    load       = '0;
    for (int k = 0; k < NCH; k++) begin
      if (wr.wr_ch == CHW'(k)) begin
        wr_ready_c = !pending[k];
        load[k]    = wr.wr_valid && !pending[k];
      end
    end
  end

  assign wr.wr_ready = wr_ready_c;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_cfg_channel #(
      .CW (CW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .ce            (ce),
      .load          (load[k]),
      .ld_count_max  (wr.wr_count_max),
      .ld_init_carr  (wr.wr_init_carr),
      .ld_count_mode (wr.wr_count_mode),
      .ld_upd_mode   (wr.wr_upd_mode),
      .carrier       (carrier_in[k*CW +: CW]),
      .count_max     (tmr_count_max[k*CW +: CW]),
      .init_carr     (tmr_init_carr[k*CW +: CW]),
      .count_mode    (tmr_count_mode[k*2 +: 2]),
      .pending       (pending[k]),
      .commit        (commit[k])
    );
  end

  // Period sync from channel 0, using the same event definition as the
  // channel commit logic but against channel 0's active configuration.
  logic [CW-1:0] c0_carr;
  logic [CW-1:0] c0_max;
  logic [1:0]    c0_mode;
  logic          c0_zero;
  logic          c0_hit_max;

  assign c0_carr    = carrier_in[CW-1:0];
  assign c0_max     = tmr_count_max[CW-1:0];
  assign c0_mode    = tmr_count_mode[1:0];
  assign c0_zero    = (c0_carr == '0);
  assign c0_hit_max = (c0_carr == c0_max) ||
                      ((c0_mode == CM_UP) && (c0_carr == (c0_max - CW'(1))));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out <= 1'b0;
    end else begin
      sync_out <= ce && event_select(sync_mode, c0_zero, c0_hit_max, 1'b0);
    end
  end

endmodule
